// File: rtl/msu_data_fetch.sv
// MSU-1 data-port fetch engine: prefetches sequential bytes from the host read channel into a FIFO.
// Define MSU_DATA_STATS_EN to add the underrun_cnt / seek_cnt statistics ports.
module msu_data_fetch #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FILL_THRESH = 4,
    parameter int unsigned MAX_OUT     = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] msu_data_addr,
    input  logic        msu_data_seek,
    output logic [7:0]  msu_data_in,
    output logic        msu_status_data_busy,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data
`ifdef MSU_DATA_STATS_EN
    ,
    output logic [15:0] underrun_cnt,
    output logic [15:0] seek_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]    r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_last_addr;
    logic [31:0]   r_req_addr;
    logic          r_req_valid;
    logic          r_busy;
    logic [7:0]    r_data;

    logic [1:0]    w_state_nxt;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_count_after_pop;
    logic [CW-1:0] w_outstanding_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic [31:0]   w_last_addr_nxt;
    logic [31:0]   w_req_addr_nxt;
    logic          w_req_valid_nxt;
    logic          w_busy_nxt;
    logic [7:0]    w_data_nxt;
    logic [7:0]    w_head;

    logic [31:0]   w_last_inc;
    logic          w_is_next;
    logic          w_is_same;
    logic          w_ext_seek;
    logic          w_advance;
    logic          w_underrun;
    logic          w_seek;
    logic          w_pop;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;

    // Event decode: explicit/implicit seek, advance, underrun (advance on an empty FIFO).
    assign w_last_inc = r_last_addr + 32'd1;
    assign w_is_next  = (msu_data_addr == w_last_inc);
    assign w_is_same  = (msu_data_addr == r_last_addr);
    assign w_ext_seek = msu_data_seek || (!w_is_same && !w_is_next);
    assign w_advance  = !msu_data_seek && w_is_next;
    assign w_underrun = w_advance && (r_count == '0);
    assign w_seek     = w_ext_seek || w_underrun;
    assign w_pop      = w_advance && !w_underrun;
    assign w_accept   = r_req_valid && req_ready;
    assign w_drop     = rsp_valid && (r_discard != '0);
    assign w_push     = rsp_valid && !w_drop && !w_seek;

    // State register and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_last_addr   <= '0;
            r_req_addr    <= '0;
            r_req_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_data        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_last_addr   <= w_last_addr_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_req_valid   <= w_req_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_data        <= w_data_nxt;
        end
    end

    // Prefetch storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= rsp_data;
        end
    end

    // Next-state and next-output logic; a seek overrides any same-cycle pop or push.
    always_comb begin
        w_state_nxt       = r_state;
        w_busy_nxt        = r_busy;
        w_req_addr_nxt    = r_req_addr;
        w_last_addr_nxt   = r_last_addr;
        w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
        w_count_after_pop = r_count - CW'(w_pop);
        w_wptr_nxt        = r_wptr + AW'(w_push);
        w_rptr_nxt        = r_rptr + AW'(w_pop);
        w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(rsp_valid);
        w_discard_nxt     = r_discard - CW'(w_drop);
        w_head            = r_data;
        w_data_nxt        = r_data;
        w_req_valid_nxt   = 1'b0;

        if (w_accept) begin
            w_req_addr_nxt = r_req_addr + 32'd1;
        end
        if (w_advance) begin
            w_last_addr_nxt = msu_data_addr;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_FILL: begin
                if ((r_count >= CW'(FILL_THRESH)) && (r_discard == '0)) begin
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Everything still in flight, including a request accepted this cycle, is stale after a seek.
        if (w_seek) begin
            w_state_nxt     = S_FILL;
            w_busy_nxt      = 1'b1;
            w_req_addr_nxt  = msu_data_addr;
            w_last_addr_nxt = msu_data_addr;
            w_count_nxt     = '0;
            w_wptr_nxt      = '0;
            w_rptr_nxt      = '0;
            w_discard_nxt   = w_outstanding_nxt;
        end

        // Head after this cycle: bypass the incoming byte when it lands in an otherwise empty FIFO.
        if (w_count_after_pop == '0) begin
            w_head = rsp_data;
        end else begin
            w_head = r_mem[w_rptr_nxt];
        end
        if (w_count_nxt != '0) begin
            w_data_nxt = w_head;
        end

        // Credit rule: buffered plus in-flight bytes never exceed the FIFO depth.
        w_req_valid_nxt = (w_state_nxt != S_IDLE)
                        && ((SW'(w_count_nxt) + SW'(w_outstanding_nxt)) < SW'(DEPTH))
                        && (w_outstanding_nxt < CW'(MAX_OUT));
    end

    assign msu_data_in          = r_data;
    assign msu_status_data_busy = r_busy;
    assign req_valid            = r_req_valid;
    assign req_addr             = r_req_addr;

`ifdef MSU_DATA_STATS_EN
    logic [15:0] r_underrun_cnt;
    logic [15:0] r_seek_cnt;

    // Saturating event counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_underrun_cnt <= '0;
            r_seek_cnt     <= '0;
        end else begin
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
            if (w_ext_seek && (r_seek_cnt != 16'hFFFF)) begin
                r_seek_cnt <= r_seek_cnt + 16'd1;
            end
        end
    end

    assign underrun_cnt = r_underrun_cnt;
    assign seek_cnt     = r_seek_cnt;
`endif

endmodule

// File: tb/tb_msu_data_fetch.sv
// Directed bench for msu_data_fetch: in-order host model with 2-cycle latency and a byte scoreboard.
module tb_msu_data_fetch;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned FILL_THRESH = 4;
    localparam int unsigned MAX_OUT     = 8;

    logic        CLK;
    logic        RST_N;
    logic [31:0] msu_data_addr;
    logic        msu_data_seek;
    logic [7:0]  msu_data_in;
    logic        msu_status_data_busy;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
`ifdef MSU_DATA_STATS_EN
    logic [15:0] underrun_cnt;
    logic [15:0] seek_cnt;
`endif

    msu_data_fetch #(
        .DEPTH       (DEPTH),
        .FILL_THRESH (FILL_THRESH),
        .MAX_OUT     (MAX_OUT)
    ) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .msu_data_addr        (msu_data_addr),
        .msu_data_seek        (msu_data_seek),
        .msu_data_in          (msu_data_in),
        .msu_status_data_busy (msu_status_data_busy),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_addr             (req_addr),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data)
`ifdef MSU_DATA_STATS_EN
        ,
        .underrun_cnt         (underrun_cnt),
        .seek_cnt             (seek_cnt)
`endif
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_rsp    = 0;
    int          hcyc     = 0;
    logic        host_hold = 1'b0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [7:0]  exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic check_head(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(msu_data_in), 32'(e));
        end
    endtask

    task automatic wait_not_busy(input string tag);
        int k;
        k = 0;
        while (msu_status_data_busy && (k < 200)) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(msu_status_data_busy), 32'd0);
    endtask

    // Host: accepts on valid&&ready, answers in order two cycles later with addr[7:0].
    initial begin
        logic [31:0] a;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                pend_addr.delete();
                pend_due.delete();
                rsp_valid = 1'b0;
            end else begin
                hcyc++;
                if (!host_hold && (pend_addr.size() > 0) && (pend_due[0] <= hcyc)) begin
                    a         = pend_addr.pop_front();
                    void'(pend_due.pop_front());
                    rsp_valid = 1'b1;
                    rsp_data  = a[7:0];
                    n_rsp++;
                end else begin
                    rsp_valid = 1'b0;
                end
                if (req_valid && req_ready) begin
                    pend_addr.push_back(req_addr);
                    pend_due.push_back(hcyc + 2);
                    n_acc++;
                end
                chk("max_outstanding", 32'(pend_addr.size() <= int'(MAX_OUT)), 32'd1);
            end
        end
    end

    initial begin
        int base;
        int k;
        int rsp_base;
        RST_N         = 1'b0;
        msu_data_addr = 32'h0;
        msu_data_seek = 1'b0;
        req_ready     = 1'b1;
        tick(3);
        chk("rst_data", 32'(msu_data_in), 32'h0);
        chk("rst_busy", 32'(msu_status_data_busy), 32'h0);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_req_addr", req_addr, 32'h0);
        RST_N = 1'b1;
        tick(3);
        chk("idle_no_req", 32'(req_valid), 32'h0);

        // Initial fill from 0x1000.
        rsp_base      = n_rsp;
        msu_data_addr = 32'h0000_1000;
        msu_data_seek = 1'b1;
        exp_q.push_back(8'h00);
        tick(1);
        msu_data_seek = 1'b0;
        chk("seek_busy", 32'(msu_status_data_busy), 32'h1);
        chk("seek_req_addr", req_addr, 32'h0000_1000);
        chk("seek_req_valid", 32'(req_valid), 32'h1);
        wait_not_busy("fill_busy_fall");
        chk("fill_thresh_reached", 32'((n_rsp - rsp_base) >= int'(FILL_THRESH)), 32'h1);
        check_head("fill_head");
        tick(30);
        chk("full_req_addr", req_addr, 32'h0000_1010);
        chk("full_req_valid", 32'(req_valid), 32'h0);

        // Sequential advances: one pop and one refill request each.
        msu_data_addr = 32'h0000_1001;
        exp_q.push_back(8'h01);
        tick(6);
        check_head("adv1_data");
        chk("adv1_busy", 32'(msu_status_data_busy), 32'h0);
        chk("adv1_req_addr", req_addr, 32'h0000_1011);
        msu_data_addr = 32'h0000_1002;
        exp_q.push_back(8'h02);
        tick(6);
        check_head("adv2_data");
        chk("adv2_busy", 32'(msu_status_data_busy), 32'h0);
        chk("adv2_req_addr", req_addr, 32'h0000_1012);

        // Seek away with five requests in flight; their bytes must be dropped.
        host_hold     = 1'b1;
        msu_data_addr = 32'h0000_3050;
        msu_data_seek = 1'b1;
        tick(1);
        msu_data_seek = 1'b0;
        base = n_acc - int'(pend_addr.size());
        k = 0;
        while (((n_acc - base) < 5) && (k < 50)) begin
            tick(1);
            k++;
        end
        req_ready = 1'b0;
        tick(2);
        chk("held_outstanding", 32'(pend_addr.size()), 32'd5);
        chk("held_busy", 32'(msu_status_data_busy), 32'h1);
        msu_data_addr = 32'h0000_2000;
        msu_data_seek = 1'b1;
        exp_q.push_back(8'h00);
        tick(1);
        msu_data_seek = 1'b0;
        req_ready     = 1'b1;
        host_hold     = 1'b0;
        chk("reseek_req_addr", req_addr, 32'h0000_2000);
        wait_not_busy("reseek_busy_fall");
        check_head("reseek_no_stale");
        tick(30);

        // Underrun: no data arrives, then the address advances.
        msu_data_addr = 32'h0000_4000;
        msu_data_seek = 1'b1;
        req_ready     = 1'b0;
        tick(1);
        msu_data_seek = 1'b0;
        tick(3);
        msu_data_addr = 32'h0000_4001;
        exp_q.push_back(8'h01);
        tick(1);
        chk("underrun_busy", 32'(msu_status_data_busy), 32'h1);
        chk("underrun_req_addr", req_addr, 32'h0000_4001);
`ifdef MSU_DATA_STATS_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
        chk("seek_cnt", 32'(seek_cnt), 32'd4);
`endif
        req_ready = 1'b1;
        wait_not_busy("underrun_busy_fall");
        check_head("underrun_refetch");
        tick(30);

        // Implicit seek near the top of the address space, then wrap.
        msu_data_addr = 32'hFFFF_FFFE;
        exp_q.push_back(8'hFE);
        tick(1);
        chk("implicit_busy", 32'(msu_status_data_busy), 32'h1);
        chk("implicit_req_addr", req_addr, 32'hFFFF_FFFE);
        wait_not_busy("wrap_busy_fall");
        check_head("wrap_fe");
        tick(30);
        chk("wrap_req_addr", req_addr, 32'h0000_000E);
        msu_data_addr = 32'hFFFF_FFFF;
        exp_q.push_back(8'hFF);
        tick(6);
        check_head("wrap_ff");
        msu_data_addr = 32'h0000_0000;
        exp_q.push_back(8'h00);
        tick(6);
        check_head("wrap_00");
        chk("wrap_busy", 32'(msu_status_data_busy), 32'h0);
        chk("wrap_req_addr2", req_addr, 32'h0000_0010);

        // Asynchronous reset during FILL with three requests in flight.
        host_hold     = 1'b1;
        msu_data_addr = 32'h0000_5000;
        msu_data_seek = 1'b1;
        tick(1);
        msu_data_seek = 1'b0;
        base = n_acc - int'(pend_addr.size());
        k = 0;
        while (((n_acc - base) < 3) && (k < 50)) begin
            tick(1);
            k++;
        end
        req_ready = 1'b0;
        tick(1);
        chk("pre_rst_outstanding", 32'(pend_addr.size()), 32'd3);
        RST_N         = 1'b0;
        msu_data_addr = 32'h0;
        #1;
        chk("arst_data", 32'(msu_data_in), 32'h0);
        chk("arst_busy", 32'(msu_status_data_busy), 32'h0);
        chk("arst_req_valid", 32'(req_valid), 32'h0);
        chk("arst_req_addr", req_addr, 32'h0);
        tick(2);
        RST_N     = 1'b1;
        req_ready = 1'b1;
        host_hold = 1'b0;
        tick(5);
        chk("post_rst_idle_valid", 32'(req_valid), 32'h0);
        chk("post_rst_idle_busy", 32'(msu_status_data_busy), 32'h0);
`ifdef MSU_DATA_STATS_EN
        chk("post_rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif

        // Clean restart after reset.
        msu_data_addr = 32'h0000_6005;
        msu_data_seek = 1'b1;
        exp_q.push_back(8'h05);
        tick(1);
        msu_data_seek = 1'b0;
        wait_not_busy("restart_busy_fall");
        check_head("restart_head");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
